// File: rtl/ksa_operand_feeder.sv
// Operand assembly and result capture around the registered Kogge-Stone adder.
// Builds a/b/c from a narrow word stream, waits out the adder latency, holds the sum.
module ksa_operand_feeder #(
  parameter int unsigned BITS     = 64,
  parameter int unsigned WORD     = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [WORD-1:0] in_data_i,
  input  logic            in_carry_i,
  output logic [BITS-1:0] op_a_o,
  output logic [BITS-1:0] op_b_o,
  output logic            op_c_o,
  input  logic [BITS:0]   sum_in_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [BITS:0]   res_sum_o,
  output logic            busy_o
);

  localparam int unsigned NW     = BITS / WORD;
  localparam int unsigned WCNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned LCNT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [WCNT_W-1:0]   wcnt_q,    wcnt_d;
  logic [LCNT_W-1:0]   lcnt_q,    lcnt_d;
  logic [BITS-1:0]     op_a_q,    op_a_d;
  logic [BITS-1:0]     op_b_q,    op_b_d;
  logic                op_c_q,    op_c_d;
  logic [BITS:0]       res_sum_q, res_sum_d;
  logic                res_valid_q, res_valid_d;

  logic accept;
  logic last_word;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_LOAD_A;
      wcnt_q      <= '0;
      lcnt_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= 1'b0;
      res_sum_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      lcnt_q      <= lcnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      res_sum_q   <= res_sum_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state, word steering and handshake decode
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    lcnt_d      = lcnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;
    res_sum_d   = res_sum_q;
    res_valid_d = res_valid_q;
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    accept      = 1'b0;
    last_word   = (wcnt_q == WCNT_W'(NW - 1));

    unique case (state_q)
      ST_LOAD_A: begin
        in_ready_o = !rst_i;
        accept     = in_valid_i && in_ready_o;
        if (accept) begin
          for (int k = 0; k < NW; k++) begin
            if (wcnt_q == WCNT_W'(k)) op_a_d[k*WORD +: WORD] = in_data_i;
          end
          if (last_word) begin
            wcnt_d  = '0;
            state_d = ST_LOAD_B;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      ST_LOAD_B: begin
        in_ready_o = !rst_i;
        accept     = in_valid_i && in_ready_o;
        if (accept) begin
          for (int k = 0; k < NW; k++) begin
            if (wcnt_q == WCNT_W'(k)) op_b_d[k*WORD +: WORD] = in_data_i;
          end
          if (last_word) begin
            // Carry-in is only meaningful alongside the final b word
            wcnt_d  = '0;
            op_c_d  = in_carry_i;
            lcnt_d  = '0;
            state_d = ST_WAIT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (lcnt_q == LCNT_W'(PIPE_LAT)) begin
          res_sum_d   = sum_in_i;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      ST_HOLD: begin
        busy_o = 1'b1;
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_LOAD_A;
        end
      end
      default: state_d = ST_LOAD_A;
    endcase
  end

  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign op_c_o      = op_c_q;
  assign res_sum_o   = res_sum_q;
  assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_ksa_operand_feeder.sv
// Self-checking bench for ksa_operand_feeder with a behavioural registered adder attached.
module tb_ksa_operand_feeder;

  localparam int unsigned BITS     = 64;
  localparam int unsigned WORD     = 16;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned NW       = BITS / WORD;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] in_data;
  logic            in_carry;
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic            op_c;
  logic [BITS:0]   sum_in;
  logic            res_valid;
  logic            res_ready;
  logic [BITS:0]   res_sum;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ksa_operand_feeder #(.BITS(BITS), .WORD(WORD), .PIPE_LAT(PIPE_LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_carry_i  (in_carry),
    .op_a_o      (op_a),
    .op_b_o      (op_b),
    .op_c_o      (op_c),
    .sum_in_i    (sum_in),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder stand-in: PIPE_LAT register stages of a + b + c
  logic [BITS:0] pipe [PIPE_LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {{BITS{1'b0}}, op_c};
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sum_in = pipe[PIPE_LAT-1];

  task automatic check(input string tag, input logic [BITS:0] obs, input logic [BITS:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one word; returns the cycle number in which it was accepted.
  task automatic send_word(input logic [WORD-1:0] d, input logic c, input int gap, output int t_acc);
    int waited;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_carry = c;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("in_ready_timeout", {{BITS{1'b0}}, in_ready}, 1);
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends nwords of the a-then-b stream; junk carry on all but the final b word.
  task automatic send_words(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic c,
                            input logic junk_c, input int gap, input int nwords, output int t_last);
    logic [WORD-1:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = (i < NW) ? a[i*WORD +: WORD] : b[(i-NW)*WORD +: WORD];
      send_word(w, (i == 2*NW-1) ? c : junk_c, (i == 0) ? 0 : gap, t_last);
    end
  endtask

  task automatic run_op(input string tag, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input logic c, input logic junk_c, input int gap, input int hold);
    int t_last;
    int n;
    logic [BITS:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, c};
    send_words(a, b, c, junk_c, gap, 2*NW, t_last);
    check({tag, "_busy_wait"}, {{BITS{1'b0}}, busy}, 1);
    check({tag, "_ready_wait"}, {{BITS{1'b0}}, in_ready}, 0);
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, {{BITS{1'b0}}, res_valid}, 1);
    check({tag, "_latency"}, (BITS+1)'(cyc - t_last), (BITS+1)'(PIPE_LAT + 2));
    check({tag, "_res_sum"}, res_sum, exp);
    check({tag, "_op_a"}, {1'b0, op_a}, {1'b0, a});
    check({tag, "_op_b"}, {1'b0, op_b}, {1'b0, b});
    check({tag, "_op_c"}, {{BITS{1'b0}}, op_c}, {{BITS{1'b0}}, c});
    // Stall the result; offered words must not be consumed meanwhile
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = WORD'($urandom);
      in_carry = 1'b1;
      @(negedge clk);
      check({tag, "_hold_sum"}, res_sum, exp);
      check({tag, "_hold_ready"}, {{BITS{1'b0}}, in_ready}, 0);
      check({tag, "_hold_valid"}, {{BITS{1'b0}}, res_valid}, 1);
      check({tag, "_hold_op_a"}, {1'b0, op_a}, {1'b0, a});
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_drain_valid"}, {{BITS{1'b0}}, res_valid}, 0);
    check({tag, "_drain_ready"}, {{BITS{1'b0}}, in_ready}, 1);
    check({tag, "_drain_busy"}, {{BITS{1'b0}}, busy}, 0);
  endtask

  initial begin
    int t_last;
    logic [BITS-1:0] ra;
    logic [BITS-1:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_carry  = 1'b0;
    res_ready = 1'b0;

    // Reset held three cycles, with in_valid asserted to prove nothing is taken
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_in_ready", {{BITS{1'b0}}, in_ready}, 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {{BITS{1'b0}}, in_ready}, 1);
    check("post_reset_res_valid", {{BITS{1'b0}}, res_valid}, 0);
    check("post_reset_op_a", {1'b0, op_a}, 0);
    check("post_reset_op_b", {1'b0, op_b}, 0);
    check("post_reset_busy", {{BITS{1'b0}}, busy}, 0);

    run_op("basic", 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 0);
    run_op("carry_in", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 0, 0);
    run_op("five_seven", 64'd5, 64'd7, 1'b0, 1'b1, 0, 0);
    run_op("bubbles", 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2, 0);
    run_op("backpressure", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0, 10);
    check("bp_res_sum_value", res_sum, 65'h0_2222_2222_2222_2212);

    // Reset after five words: the partial load must leave no residue
    send_words(64'hAAAA_BBBB_CCCC_DDDD, 64'hEEEE_FFFF_1111_2222, 1'b1, 1'b1, 0, 5, t_last);
    rst = 1'b1;
    @(negedge clk);
    check("midload_rst_ready", {{BITS{1'b0}}, in_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midload_op_a_clr", {1'b0, op_a}, 0);
    check("midload_op_b_clr", {1'b0, op_b}, 0);
    run_op("after_midload", 64'd3, 64'd4, 1'b0, 1'b0, 0, 0);

    // Reset during WAIT: the aborted op must never raise res_valid
    send_words(64'd100, 64'd200, 1'b0, 1'b0, 0, 2*NW, t_last);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("wait_rst_no_valid", {{BITS{1'b0}}, res_valid}, 0);
    end
    check("wait_rst_ready", {{BITS{1'b0}}, in_ready}, 1);
    check("wait_rst_busy", {{BITS{1'b0}}, busy}, 0);
    run_op("after_wait_rst", 64'd3, 64'd4, 1'b0, 1'b1, 0, 0);

    // Randomised operands, carries, bubble gaps and result stalls
    for (int i = 0; i < 8; i++) begin
      ra = {32'($urandom), 32'($urandom)};
      rb = {32'($urandom), 32'($urandom)};
      run_op("random", ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
